// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-stage definitions: funct3 encodings, writeback error causes,
// the memory FSM state type and access legality helpers.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    function automatic logic access_illegal(input logic rd_en, input logic wr_en,
                                            input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        if (rd_en && wr_en)
            bad = 1'b1;
        else if (rd_en)
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        else if (wr_en)
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        return bad;
    endfunction

    // Only meaningful for encodings that already passed access_illegal.
    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store enables and replicated store data, and load
// extraction with sign or zero extension.
module mem_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wr_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wr_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wr_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel  = rdata_i[{off_i, 3'b000} +: 8];
        half_sel  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = rdata_i;
        case (funct3_i)
            F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ld_data_o = {24'h0, byte_sel};
            F3_HU:   ld_data_o = {16'h0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: valid/ready data-memory access with stall and
// timeout abort, load formatting, and the MEM/WB boundary register.
//   state   | meaning
//   ST_IDLE | no access outstanding; legal requests go out combinationally
//   ST_BUSY | access outstanding, request fields held from latched copies
module mem_stage
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write_en,
    input  logic        mem_read,
    input  logic        mem_to_reg,
    input  logic [31:0] mem_addr,
    input  logic [31:0] wr_data,
    input  logic [31:0] alu_val,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_err
);

    mem_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d, m2r_q, m2r_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [1:0]  wb_err_q, wb_err_d;

    logic        acc, illegal, misalign, go, busy, timeout;
    logic        is_store, m2r_sel;
    logic [4:0]  rd_sel;
    logic [2:0]  f3_sel;
    logic [1:0]  off_sel, err;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, ld_data;

    assign acc      = mem_read | mem_write_en;
    assign illegal  = acc & access_illegal(mem_read, mem_write_en, funct3);
    assign misalign = acc & ~illegal & access_misaligned(funct3, mem_addr[1:0]);
    assign go       = acc & ~illegal & ~misalign;
    assign busy     = (state_q == ST_BUSY);
    assign timeout  = busy & ~dmem_ready & (cnt_q == CNT_W'(TIMEOUT - 1));

    assign f3_sel   = busy ? f3_q  : funct3;
    assign off_sel  = busy ? off_q : mem_addr[1:0];
    assign rd_sel   = busy ? rd_q  : rd;
    assign m2r_sel  = busy ? m2r_q : mem_to_reg;
    assign is_store = busy ? we_q  : mem_write_en;

    mem_align u_align (
        .funct3_i  (f3_sel),
        .off_i     (off_sel),
        .wr_data_i (wr_data),
        .rdata_i   (dmem_rdata),
        .be_o      (be_c),
        .wdata_o   (wdata_c),
        .ld_data_o (ld_data)
    );

    assign dmem_req   = busy | go;
    assign dmem_we    = busy ? we_q : (go & mem_write_en);
    assign dmem_addr  = busy ? addr_q : {mem_addr[31:2], 2'b00};
    assign dmem_be    = busy ? be_q : be_c;
    assign dmem_wdata = busy ? wdata_q : wdata_c;
    // The abort cycle retires like a completion, so the pipeline is released.
    assign stall      = busy ? (~dmem_ready & ~timeout) : (go & ~dmem_ready);

    always_comb begin
        if (busy)          err = timeout ? ERR_TIMEOUT : ERR_NONE;
        else if (illegal)  err = ERR_ILLEGAL;
        else if (misalign) err = ERR_MISALIGN;
        else               err = ERR_NONE;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        off_d   = off_q;
        m2r_d   = m2r_q;
        if (!busy) begin
            if (go && !dmem_ready) begin
                state_d = ST_BUSY;
                cnt_d   = '0;
                addr_d  = {mem_addr[31:2], 2'b00};
                we_d    = mem_write_en;
                be_d    = be_c;
                wdata_d = wdata_c;
                rd_d    = rd;
                f3_d    = funct3;
                off_d   = mem_addr[1:0];
                m2r_d   = mem_to_reg;
            end
        end else if (dmem_ready || timeout) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        wb_valid_d = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = wb_data_q;
        wb_err_d   = ERR_NONE;
        if (!stall) begin
            wb_valid_d = acc | (rd_sel != 5'd0);
            wb_rd_d    = ((err != ERR_NONE) || is_store) ? 5'd0 : rd_sel;
            wb_data_d  = m2r_sel ? ld_data : alu_val;
            wb_err_d   = err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            m2r_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_err_q   <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            m2r_q      <= m2r_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors for stores, loads with
// wait states, misaligned/illegal accesses, timeout abort and mid-access reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write_en, mem_read, mem_to_reg;
    logic [31:0] mem_addr, wr_data, alu_val;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_write_en (mem_write_en),
        .mem_read     (mem_read),
        .mem_to_reg   (mem_to_reg),
        .mem_addr     (mem_addr),
        .wr_data      (wr_data),
        .alu_val      (alu_val),
        .rd           (rd),
        .funct3       (funct3),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_err       (wb_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic m2r,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] alu, input logic [4:0] r, input logic [2:0] f3);
        mem_write_en = we;
        mem_read     = re;
        mem_to_reg   = m2r;
        mem_addr     = addr;
        wr_data      = wd;
        alu_val      = alu;
        rd           = r;
        funct3       = f3;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Loads through a wait-stated read; expects stall for n_wait cycles.
    task automatic load_wait(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int n_wait, input logic [31:0] exp);
        drive(1'b0, 1'b1, 1'b1, addr, 32'h0, 32'h0, 5'd3, f3);
        dmem_rdata = rdata;
        for (int i = 0; i <= n_wait; i++) begin
            dmem_ready = (i == n_wait);
            #4;
            check_val({tag, "_stall"}, 32'(stall), 32'(i < n_wait));
            check_val({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
            next_cycle();
            if (i < n_wait) check_val({tag, "_bubble"}, 32'(wb_valid), 32'd0);
        end
        check_val({tag, "_data"}, wb_data, exp);
        check_val({tag, "_rd"}, 32'(wb_rd), 32'd3);
        check_val({tag, "_err"}, 32'(wb_err), 32'd0);
        drive_idle();
        dmem_ready = 1'b0;
    endtask

    initial begin
        int  stalls;
        logic seen_end;

        rst = 1'b1;
        drive_idle();
        dmem_rdata = 32'h0;
        dmem_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #4;
        check_val("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_val("rst_wb_rd", 32'(wb_rd), 32'd0);
        check_val("rst_wb_err", 32'(wb_err), 32'd0);
        check_val("rst_req", 32'(dmem_req), 32'd0);
        check_val("rst_stall", 32'(stall), 32'd0);
        next_cycle();

        // SB to the top byte lane with same-cycle ready.
        drive(1'b1, 1'b0, 1'b0, 32'h1003, 32'hAB, 32'h0, 5'd7, 3'b000);
        dmem_ready = 1'b1;
        #4;
        check_val("sb_stall", 32'(stall), 32'd0);
        check_val("sb_req", 32'(dmem_req), 32'd1);
        check_val("sb_we", 32'(dmem_we), 32'd1);
        check_val("sb_be", 32'(dmem_be), 32'b1000);
        check_val("sb_wdata", dmem_wdata, 32'hABABABAB);
        check_val("sb_addr", dmem_addr, 32'h1000);
        next_cycle();
        check_val("sb_wb_rd", 32'(wb_rd), 32'd0);
        check_val("sb_wb_valid", 32'(wb_valid), 32'd1);
        drive_idle();
        dmem_ready = 1'b0;

        // SH to upper half.
        drive(1'b1, 1'b0, 1'b0, 32'h7002, 32'h1234ABCD, 32'h0, 5'd0, 3'b001);
        dmem_ready = 1'b1;
        #4;
        check_val("sh_be", 32'(dmem_be), 32'b1100);
        check_val("sh_wdata", dmem_wdata, 32'hABCDABCD);
        next_cycle();
        drive_idle();
        dmem_ready = 1'b0;

        load_wait("lb",  3'b000, 32'h2001, 32'h0000_8000, 3, 32'hFFFFFF80);
        load_wait("lbu", 3'b100, 32'h2001, 32'h0000_8000, 3, 32'h00000080);
        load_wait("lh",  3'b001, 32'h7002, 32'hBEEF_0000, 0, 32'hFFFFBEEF);
        load_wait("lhu", 3'b101, 32'h7002, 32'hBEEF_0000, 1, 32'h0000BEEF);

        // Misaligned LW.
        drive(1'b0, 1'b1, 1'b1, 32'h3002, 32'h0, 32'h0, 5'd4, 3'b010);
        #4;
        check_val("mis_req", 32'(dmem_req), 32'd0);
        check_val("mis_stall", 32'(stall), 32'd0);
        next_cycle();
        check_val("mis_err", 32'(wb_err), 32'd1);
        check_val("mis_rd", 32'(wb_rd), 32'd0);
        check_val("mis_valid", 32'(wb_valid), 32'd1);
        drive_idle();

        // LH that never gets ready: 16 stalled cycles then abort.
        drive(1'b0, 1'b1, 1'b1, 32'h4002, 32'h0, 32'h0, 5'd6, 3'b001);
        stalls   = 0;
        seen_end = 1'b0;
        for (int c = 0; c < 40 && !seen_end; c++) begin
            #4;
            if (stall) stalls++;
            else seen_end = 1'b1;
            next_cycle();
        end
        check_val("to_seen", 32'(seen_end), 32'd1);
        check_val("to_stalls", 32'(stalls), 32'd16);
        check_val("to_err", 32'(wb_err), 32'd2);
        check_val("to_rd", 32'(wb_rd), 32'd0);
        drive_idle();
        #4;
        check_val("to_idle_req", 32'(dmem_req), 32'd0);
        check_val("to_idle_stall", 32'(stall), 32'd0);
        next_cycle();

        // Reset on the 2nd BUSY cycle of an SW.
        drive(1'b1, 1'b0, 1'b0, 32'h5000, 32'hDEADBEEF, 32'h0, 5'd0, 3'b010);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #4;
        check_val("sw_busy_addr", dmem_addr, 32'h5000);
        check_val("sw_busy_be", 32'(dmem_be), 32'hF);
        next_cycle();
        rst = 1'b0;
        drive_idle();
        #4;
        check_val("rstb_req", 32'(dmem_req), 32'd0);
        check_val("rstb_stall", 32'(stall), 32'd0);
        check_val("rstb_valid", 32'(wb_valid), 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b1, 32'h6004, 32'h0, 32'h0, 5'd9, 3'b010);
        dmem_rdata = 32'h12345678;
        dmem_ready = 1'b1;
        #4;
        check_val("lw_req", 32'(dmem_req), 32'd1);
        check_val("lw_stall", 32'(stall), 32'd0);
        next_cycle();
        check_val("lw_data", wb_data, 32'h12345678);
        check_val("lw_rd", 32'(wb_rd), 32'd9);
        drive_idle();
        dmem_ready = 1'b0;

        // Read and write both set.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd1, 3'b010);
        #4;
        check_val("ill_req", 32'(dmem_req), 32'd0);
        next_cycle();
        check_val("ill_err", 32'(wb_err), 32'd3);
        check_val("ill_rd", 32'(wb_rd), 32'd0);

        // Plain ALU op.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234, 5'd5, 3'b000);
        next_cycle();
        check_val("alu_valid", 32'(wb_valid), 32'd1);
        check_val("alu_rd", 32'(wb_rd), 32'd5);
        check_val("alu_data", wb_data, 32'h1234);
        check_val("alu_err", 32'(wb_err), 32'd0);

        // Stray ready with nothing requested.
        drive_idle();
        dmem_ready = 1'b1;
        #4;
        check_val("stray_req", 32'(dmem_req), 32'd0);
        check_val("stray_stall", 32'(stall), 32'd0);
        next_cycle();
        check_val("stray_valid", 32'(wb_valid), 32'd0);
        dmem_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
